hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit.sv | 151 +++++++++++++++
 tb/tb_hazard_forward_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding unit for a 5-stage in-order pipeline.
// Tracks the instructions in EX and MEM, registers the EX operand-forward
// selects for the instruction leaving ID, detects load-use hazards (stall),
// passes taken-branch squashes through as flush, and counts stall cycles
// with saturation.
module hazard_forward_unit #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [REG_NUM_BITWIDTH-1:0] idRs1,
    input  logic [REG_NUM_BITWIDTH-1:0] idRs2,
    input  logic                        idUsesRs1,
    input  logic                        idUsesRs2,
    input  logic [REG_NUM_BITWIDTH-1:0] idRd,
    input  logic                        idRegWrite,
    input  logic                        idMemRead,
    input  logic                        branchTaken,
    output logic [1:0]                  forwardA,
    output logic [1:0]                  forwardB,
    output logic                        stall,
    output logic                        flush,
    output logic [COUNT_WIDTH-1:0]      hazardCount
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_EX  = 2'b10;

    localparam logic [REG_NUM_BITWIDTH-1:0] REG_ZERO  = {REG_NUM_BITWIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0]      COUNT_MAX = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0]      COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    // A pipeline slot produces a source operand only if it really writes a
    // non-zero register that the ID instruction actually reads.
    function automatic logic slot_match(
        input logic                        valid,
        input logic                        reg_write,
        input logic [REG_NUM_BITWIDTH-1:0] rd,
        input logic [REG_NUM_BITWIDTH-1:0] rs,
        input logic                        uses
    );
        return valid && reg_write && uses && (rd == rs) && (rd != REG_ZERO);
    endfunction

    // EX slot
    logic                        ex_valid_r;
    logic [REG_NUM_BITWIDTH-1:0] ex_rd_r;
    logic                        ex_reg_write_r;
    logic                        ex_mem_read_r;
    // MEM slot
    logic                        mem_valid_r;
    logic [REG_NUM_BITWIDTH-1:0] mem_rd_r;
    logic                        mem_reg_write_r;
    logic                        mem_mem_read_r;

    logic [1:0]             forward_a_r;
    logic [1:0]             forward_b_r;
    logic [COUNT_WIDTH-1:0] hazard_count_r;

    logic       ex_match_rs1_s;
    logic       ex_match_rs2_s;
    logic       mem_match_rs1_s;
    logic       mem_match_rs2_s;
    logic       stall_s;
    logic       hold_s;
    logic [1:0] forward_a_next_s;
    logic [1:0] forward_b_next_s;

    assign ex_match_rs1_s  = slot_match(ex_valid_r,  ex_reg_write_r,  ex_rd_r,  idRs1, idUsesRs1);
    assign ex_match_rs2_s  = slot_match(ex_valid_r,  ex_reg_write_r,  ex_rd_r,  idRs2, idUsesRs2);
    assign mem_match_rs1_s = slot_match(mem_valid_r, mem_reg_write_r, mem_rd_r, idRs1, idUsesRs1);
    assign mem_match_rs2_s = slot_match(mem_valid_r, mem_reg_write_r, mem_rd_r, idRs2, idUsesRs2);

    // A taken branch squashes the dependent instruction, so it overrides load-use.
    assign stall_s = (ex_match_rs1_s || ex_match_rs2_s) && ex_mem_read_r && !branchTaken;
    assign hold_s  = stall_s || branchTaken;

    // Next operand selects: bubble on hold, otherwise newest producer wins.
    always_comb begin
        forward_a_next_s = FWD_RF;
        forward_b_next_s = FWD_RF;
        if (hold_s) begin
            forward_a_next_s = FWD_RF;
            forward_b_next_s = FWD_RF;
        end else begin
            if (ex_match_rs1_s) begin
                forward_a_next_s = FWD_EX;
            end else if (mem_match_rs1_s) begin
                forward_a_next_s = FWD_MEM;
            end else begin
                forward_a_next_s = FWD_RF;
            end
            if (ex_match_rs2_s) begin
                forward_b_next_s = FWD_EX;
            end else if (mem_match_rs2_s) begin
                forward_b_next_s = FWD_MEM;
            end else begin
                forward_b_next_s = FWD_RF;
            end
        end
    end

    // Advance the EX/MEM slots, register forward selects, count stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_r      <= 1'b0;
            ex_rd_r         <= REG_ZERO;
            ex_reg_write_r  <= 1'b0;
            ex_mem_read_r   <= 1'b0;
            mem_valid_r     <= 1'b0;
            mem_rd_r        <= REG_ZERO;
            mem_reg_write_r <= 1'b0;
            mem_mem_read_r  <= 1'b0;
            forward_a_r     <= FWD_RF;
            forward_b_r     <= FWD_RF;
            hazard_count_r  <= {COUNT_WIDTH{1'b0}};
        end else begin
            mem_valid_r     <= ex_valid_r;
            mem_rd_r        <= ex_rd_r;
            mem_reg_write_r <= ex_reg_write_r;
            mem_mem_read_r  <= ex_mem_read_r;
            if (hold_s) begin
                ex_valid_r     <= 1'b0;
                ex_rd_r        <= REG_ZERO;
                ex_reg_write_r <= 1'b0;
                ex_mem_read_r  <= 1'b0;
            end else begin
                ex_valid_r     <= 1'b1;
                ex_rd_r        <= idRd;
                ex_reg_write_r <= idRegWrite;
                ex_mem_read_r  <= idMemRead;
            end
            forward_a_r <= forward_a_next_s;
            forward_b_r <= forward_b_next_s;
            if (stall_s && (hazard_count_r != COUNT_MAX)) begin
                hazard_count_r <= hazard_count_r + COUNT_ONE;
            end else begin
                hazard_count_r <= hazard_count_r;
            end
        end
    end

    assign forwardA    = forward_a_r;
    assign forwardB    = forward_b_r;
    assign stall       = stall_s;
    assign flush       = branchTaken;
    assign hazardCount = hazard_count_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed instruction sequences, a
// pipeline-occupancy model checked every negative edge, and literal
// expectations at the interesting points. A second instance with a narrow
// counter exercises saturation within a short run.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] idRs1, idRs2, idRd;
    logic       idUsesRs1, idUsesRs2, idRegWrite, idMemRead, branchTaken;

    logic [1:0]  forwardA, forwardB;
    logic        stall, flush;
    logic [15:0] hazardCount;

    logic [1:0]  s_forwardA, s_forwardB;
    logic        s_stall, s_flush;
    logic [4:0]  s_hazardCount;

    int passed = 0;
    int total  = 0;

    hazard_forward_unit dut (
        .clk(clk), .rst(rst),
        .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
        .idRd(idRd), .idRegWrite(idRegWrite), .idMemRead(idMemRead),
        .branchTaken(branchTaken),
        .forwardA(forwardA), .forwardB(forwardB), .stall(stall), .flush(flush),
        .hazardCount(hazardCount)
    );

    hazard_forward_unit #(.REG_NUM_BITWIDTH(5), .COUNT_WIDTH(5)) u_sat (
        .clk(clk), .rst(rst),
        .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
        .idRd(idRd), .idRegWrite(idRegWrite), .idMemRead(idMemRead),
        .branchTaken(branchTaken),
        .forwardA(s_forwardA), .forwardB(s_forwardB), .stall(s_stall), .flush(s_flush),
        .hazardCount(s_hazardCount)
    );

    always #5 clk = ~clk;

    // ---------------- model: occupancy of EX (index 0) and MEM (index 1)
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } instr_t;

    instr_t     stage [2];
    logic [1:0] m_fwd_a = 2'b00;
    logic [1:0] m_fwd_b = 2'b00;
    int         m_cnt   = 0;

    initial begin
        stage[0] = '0;
        stage[1] = '0;
    end

    function automatic logic produces(input instr_t p, input logic [4:0] rs, input logic uses);
        return uses && p.valid && p.wr && (p.rd == rs) && (p.rd != 5'd0);
    endfunction

    // Youngest in-flight producer of rs decides the source.
    function automatic logic [1:0] exp_fwd(input logic [4:0] rs, input logic uses);
        for (int i = 0; i < 2; i++) begin
            if (produces(stage[i], rs, uses)) return (i == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic model_stall();
        return stage[0].ld && !branchTaken &&
               (produces(stage[0], idRs1, idUsesRs1) || produces(stage[0], idRs2, idUsesRs2));
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Model advances one instruction per edge; stall/flush inject a bubble.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stage[0] <= '0;
            stage[1] <= '0;
            m_fwd_a  <= 2'b00;
            m_fwd_b  <= 2'b00;
            m_cnt    <= 0;
        end else begin
            m_cnt    <= m_cnt + (model_stall() ? 1 : 0);
            m_fwd_a  <= (model_stall() || branchTaken) ? 2'b00 : exp_fwd(idRs1, idUsesRs1);
            m_fwd_b  <= (model_stall() || branchTaken) ? 2'b00 : exp_fwd(idRs2, idUsesRs2);
            stage[1] <= stage[0];
            stage[0] <= (model_stall() || branchTaken) ? instr_t'('0)
                                                       : instr_t'({1'b1, idRd, idRegWrite, idMemRead});
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Every negative edge: DUT outputs against the model.
    always @(negedge clk) begin
        check("cyc_stall",     32'(stall),         32'(model_stall()));
        check("cyc_flush",     32'(flush),         32'(branchTaken));
        check("cyc_forwardA",  32'(forwardA),      32'(m_fwd_a));
        check("cyc_forwardB",  32'(forwardB),      32'(m_fwd_b));
        check("cyc_count",     32'(hazardCount),   32'(sat(m_cnt, 65535)));
        check("cyc_sat_stall", 32'(s_stall),       32'(model_stall()));
        check("cyc_sat_count", 32'(s_hazardCount), 32'(sat(m_cnt, 31)));
    end

    // ---------------- stimulus
    task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic wr,
                          input logic ld, input logic br);
        idRs1 = rs1; idUsesRs1 = u1; idRs2 = rs2; idUsesRs2 = u2;
        idRd = rd; idRegWrite = wr; idMemRead = ld; branchTaken = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    initial begin
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_forwardA", 32'(forwardA),    32'd0);
        check("reset_forwardB", 32'(forwardB),    32'd0);
        check("reset_stall",    32'(stall),       32'd0);
        check("reset_count",    32'(hazardCount), 32'd0);
        rst = 1'b0;
        nops(2);

        // EX/MEM forward: add x5 ; sub x8, x5, x6
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        #1 check("exmem_no_stall", 32'(stall), 32'd0);
        tick();
        check("exmem_forwardA", 32'(forwardA), 32'd2);
        check("exmem_forwardB", 32'(forwardB), 32'd0);

        // MEM/WB forward: add x7 ; nop ; or x9, x1, x7
        nops(2);
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        nops(1);
        set_id(5'd1, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        check("memwb_forwardB", 32'(forwardB), 32'd1);
        check("memwb_forwardA", 32'(forwardA), 32'd0);

        // Load-use: lw x3 ; add x10, x3, x3
        nops(2);
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd3, 1'b1, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        #1 check("lu_stall_on", 32'(stall), 32'd1);
        check("lu_count_before", 32'(hazardCount), 32'd0);
        tick();
        check("lu_count_after", 32'(hazardCount), 32'd1);
        check("lu_stall_off",   32'(stall),       32'd0);
        check("lu_bubble_fwdA", 32'(forwardA),    32'd0);
        tick();
        check("lu_forwardA", 32'(forwardA), 32'd1);
        check("lu_forwardB", 32'(forwardB), 32'd1);

        // Priority: add x4 ; add x4 ; sub x11, x4
        nops(2);
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        set_id(5'd4, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        tick();
        check("prio_forwardA", 32'(forwardA), 32'd2);

        // x0: add x0 ; sub x13, x0
        nops(2);
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(5'd0, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
        tick();
        check("x0_forwardA", 32'(forwardA), 32'd0);

        // x0 load: lw x0 ; add x14, x0, x0 must not stall
        nops(2);
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0);
        #1 check("x0_load_no_stall", 32'(stall), 32'd0);
        tick();

        // Flush beats stall: lw x2 ; use x2 while branch taken
        nops(2);
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b1);
        #1 check("fl_flush", 32'(flush), 32'd1);
        check("fl_stall", 32'(stall), 32'd0);
        tick();
        check("fl_forwardA", 32'(forwardA),    32'd0);
        check("fl_count",    32'(hazardCount), 32'd1);

        // Saturation: lw x3, (x3) repeated stalls every other cycle (45 stalls)
        nops(2);
        set_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        repeat (90) tick();
        check("sat_narrow_count", 32'(s_hazardCount), 32'd31);
        check("sat_wide_count",   32'(hazardCount),   32'd46);

        // Reset mid-stall
        for (int i = 0; i < 4; i++) begin
            if (stall === 1'b1) break;
            tick();
        end
        check("midstall_found", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_stall",       32'(stall),         32'd0);
        check("rst_count",       32'(hazardCount),   32'd0);
        check("rst_narrow_count", 32'(s_hazardCount), 32'd0);
        tick();
        rst = 1'b0;
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        check("post_rst_forwardA", 32'(forwardA), 32'd2);
        nops(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
